// File: rtl/maze_pkg.sv
// Shared types and constants for the MazeRunner command link.
package maze_pkg;

    localparam int         BAUD_DIV_50M_19K2 = 2604;
    localparam logic [7:0] POS_ACK           = 8'hA5;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic {
        ASM_WAIT_HI = 1'b0,
        ASM_WAIT_LO = 1'b1
    } asm_state_t;

    typedef enum logic {
        TX_IDLE = 1'b0,
        TX_XMIT = 1'b1
    } tx_state_t;

    // 8N1 frame, shifted out LSB first: start bit, data, stop bit.
    function automatic logic [9:0] tx_frame(input logic [7:0] data);
        return {1'b1, data, 1'b0};
    endfunction

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling, stop-bit check.
module uart_rx_core
    import maze_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_50M_19K2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       RX,
    output logic [7:0] rx_byte,
    output logic       byte_rdy,
    output logic       frm_err,
    output logic       rx_idle
);

    localparam int            CW      = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);

    rx_state_t     state_r, state_s;
    logic          rx_meta_r, rx_sync_r, rx_prev_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic          cnt_zero_s, fall_s;
    logic          ld_half_s, ld_full_s, sample_s, stop_s;

    assign cnt_zero_s = (cnt_r == {CW{1'b0}});
    assign fall_s     = rx_prev_r & ~rx_sync_r;
    assign rx_idle    = (state_r == RX_IDLE);

    // Synchronizer plus one extra stage for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_sync_r <= 1'b1;
            rx_prev_r <= 1'b1;
        end else begin
            rx_meta_r <= RX;
            rx_sync_r <= rx_meta_r;
            rx_prev_r <= rx_sync_r;
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_r <= RX_IDLE;
        else        state_r <= state_s;
    end

    // RX next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            RX_IDLE:  if (fall_s) state_s = RX_START; else state_s = RX_IDLE;
            RX_START: if (cnt_zero_s) state_s = rx_sync_r ? RX_IDLE : RX_DATA;
                      else state_s = RX_START;
            RX_DATA:  if (cnt_zero_s && bit_idx_r == 3'd7) state_s = RX_STOP;
                      else state_s = RX_DATA;
            RX_STOP:  if (cnt_zero_s) state_s = RX_IDLE; else state_s = RX_STOP;
            default:  state_s = RX_IDLE;
        endcase
    end

    // RX datapath strobes decoded from the current state.
    always_comb begin
        ld_half_s = 1'b0;
        ld_full_s = 1'b0;
        sample_s  = 1'b0;
        stop_s    = 1'b0;
        case (state_r)
            RX_IDLE:  ld_half_s = fall_s;
            RX_START: ld_full_s = cnt_zero_s & ~rx_sync_r;
            RX_DATA:  begin
                ld_full_s = cnt_zero_s;
                sample_s  = cnt_zero_s;
            end
            RX_STOP:  stop_s = cnt_zero_s;
            default:  ld_half_s = 1'b0;
        endcase
    end

    // Bit timer, data shift register and the byte/error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r     <= {CW{1'b0}};
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            rx_byte   <= 8'h00;
            byte_rdy  <= 1'b0;
            frm_err   <= 1'b0;
        end else begin
            byte_rdy <= 1'b0;
            frm_err  <= 1'b0;
            if (ld_half_s) begin
                cnt_r     <= HALF_LD;
                bit_idx_r <= 3'd0;
            end else if (ld_full_s) begin
                cnt_r <= FULL_LD;
            end else if (!cnt_zero_s) begin
                cnt_r <= cnt_r - CW'(1);
            end
            if (sample_s) begin
                shift_r   <= {rx_sync_r, shift_r[7:1]};
                bit_idx_r <= bit_idx_r + 3'd1;
            end
            if (stop_s) begin
                if (rx_sync_r) begin
                    rx_byte  <= shift_r;
                    byte_rdy <= 1'b1;
                end else begin
                    frm_err <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cmd_uart_link.sv
// Command link: assembles two received bytes into a 16-bit command and sends 8-bit responses.
module cmd_uart_link
    import maze_pkg::*;
#(
    parameter int BAUD_DIV = BAUD_DIV_50M_19K2,
    parameter int BYTE_TMO = 1 << 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic [7:0]  resp,
    input  logic        send_resp,
    output logic        tx_busy,
    output logic        resp_sent,
    output logic        frm_err
);

    localparam int            CW      = $clog2(BAUD_DIV) + 1;
    localparam logic [CW-1:0] FULL_LD = CW'(BAUD_DIV - 1);
    localparam int            TW      = $clog2(BYTE_TMO + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(BYTE_TMO);

    logic [7:0]    rx_byte_s;
    logic          byte_rdy_s, rx_idle_s;
    asm_state_t    asm_state_r, asm_state_s;
    logic [7:0]    hold_r;
    logic [TW-1:0] tmo_cnt_r;
    logic          tmo_hit_s, hi_cap_s, lo_cap_s;
    tx_state_t     tx_state_r, tx_state_s;
    logic [9:0]    tx_shift_r;
    logic [CW-1:0] tx_cnt_r;
    logic [3:0]    tx_bits_r;
    logic          tx_zero_s, tx_load_s, tx_step_s, tx_done_s;

    uart_rx_core #(.BAUD_DIV(BAUD_DIV)) u_rx (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .rx_byte  (rx_byte_s),
        .byte_rdy (byte_rdy_s),
        .frm_err  (frm_err),
        .rx_idle  (rx_idle_s)
    );

    // Resync only while the receiver is idle so an in-flight low byte is not split.
    assign tmo_hit_s = (tmo_cnt_r == TMO_MAX) & rx_idle_s;
    assign tx_zero_s = (tx_cnt_r == {CW{1'b0}});
    assign TX        = tx_shift_r[0];

    // Assembler and TX state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            asm_state_r <= ASM_WAIT_HI;
            tx_state_r  <= TX_IDLE;
        end else begin
            asm_state_r <= asm_state_s;
            tx_state_r  <= tx_state_s;
        end
    end

    // Assembler and TX next-state logic.
    always_comb begin
        asm_state_s = asm_state_r;
        case (asm_state_r)
            ASM_WAIT_HI: if (!frm_err && byte_rdy_s) asm_state_s = ASM_WAIT_LO;
                         else asm_state_s = ASM_WAIT_HI;
            ASM_WAIT_LO: if (frm_err || byte_rdy_s || tmo_hit_s) asm_state_s = ASM_WAIT_HI;
                         else asm_state_s = ASM_WAIT_LO;
            default:     asm_state_s = ASM_WAIT_HI;
        endcase
        tx_state_s = tx_state_r;
        case (tx_state_r)
            TX_IDLE: if (send_resp) tx_state_s = TX_XMIT; else tx_state_s = TX_IDLE;
            TX_XMIT: if (tx_zero_s && tx_bits_r == 4'd9) tx_state_s = TX_IDLE;
                     else tx_state_s = TX_XMIT;
            default: tx_state_s = TX_IDLE;
        endcase
    end

    // Datapath strobes decoded from the current states.
    always_comb begin
        hi_cap_s  = 1'b0;
        lo_cap_s  = 1'b0;
        tx_load_s = 1'b0;
        tx_step_s = 1'b0;
        tx_done_s = 1'b0;
        case (asm_state_r)
            ASM_WAIT_HI: hi_cap_s = byte_rdy_s;
            ASM_WAIT_LO: lo_cap_s = byte_rdy_s;
            default:     hi_cap_s = 1'b0;
        endcase
        case (tx_state_r)
            TX_IDLE: tx_load_s = send_resp;
            TX_XMIT: begin
                tx_step_s = tx_zero_s & (tx_bits_r != 4'd9);
                tx_done_s = tx_zero_s & (tx_bits_r == 4'd9);
            end
            default: tx_load_s = 1'b0;
        endcase
    end

    // Holding byte, timeout counter, command word and its ready flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_r    <= 8'h00;
            tmo_cnt_r <= {TW{1'b0}};
            cmd       <= 16'h0000;
            cmd_rdy   <= 1'b0;
        end else begin
            if (hi_cap_s) hold_r <= rx_byte_s;
            if (hi_cap_s) begin
                tmo_cnt_r <= {TW{1'b0}};
            end else if (asm_state_r == ASM_WAIT_LO && tmo_cnt_r != TMO_MAX) begin
                tmo_cnt_r <= tmo_cnt_r + TW'(1);
            end
            if (lo_cap_s) cmd <= {hold_r, rx_byte_s};
            if (lo_cap_s) begin
                cmd_rdy <= 1'b1;
            end else if (hi_cap_s || clr_cmd_rdy) begin
                cmd_rdy <= 1'b0;
            end
        end
    end

    // Response shifter; TX idles high because the register refills with ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_shift_r <= 10'h3FF;
            tx_cnt_r   <= {CW{1'b0}};
            tx_bits_r  <= 4'd0;
            tx_busy    <= 1'b0;
            resp_sent  <= 1'b0;
        end else if (tx_load_s) begin
            tx_shift_r <= tx_frame(resp);
            tx_cnt_r   <= FULL_LD;
            tx_bits_r  <= 4'd0;
            tx_busy    <= 1'b1;
            resp_sent  <= 1'b0;
        end else if (tx_step_s) begin
            tx_shift_r <= {1'b1, tx_shift_r[9:1]};
            tx_cnt_r   <= FULL_LD;
            tx_bits_r  <= tx_bits_r + 4'd1;
        end else if (tx_done_s) begin
            tx_shift_r <= 10'h3FF;
            tx_busy    <= 1'b0;
            resp_sent  <= 1'b1;
        end else if (!tx_zero_s) begin
            tx_cnt_r <= tx_cnt_r - CW'(1);
        end
    end

endmodule

// File: tb/tb_cmd_uart_link.sv
// Self-checking bench for cmd_uart_link with a cycle-level reference model of the link.
module tb_cmd_uart_link;

    localparam int B   = 16;
    localparam int H   = B / 2;
    localparam int TMO = 200;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd;
    logic        cmd_rdy;
    logic        clr_cmd_rdy = 1'b0;
    logic [7:0]  resp = 8'h00;
    logic        send_resp = 1'b0;
    logic        tx_busy;
    logic        resp_sent;
    logic        frm_err;

    cmd_uart_link #(.BAUD_DIV(B), .BYTE_TMO(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .RX          (RX),
        .TX          (TX),
        .cmd         (cmd),
        .cmd_rdy     (cmd_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .resp        (resp),
        .send_resp   (send_resp),
        .tx_busy     (tx_busy),
        .resp_sent   (resp_sent),
        .frm_err     (frm_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         at;
        int         start;
        logic [7:0] b;
        bit         ok;
    } rx_ev_t;

    rx_ev_t      evq[$];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          n_fail_shown = 0;
    int          frm_seen = 0;

    // Reference model state.
    logic [15:0] m_cmd;
    logic        m_rdy, m_lo, m_frm, m_tx_on, m_sent;
    logic [7:0]  m_hold;
    int          m_hi_at, m_tx_s;
    logic [9:0]  m_tx_frame;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail_shown++;
            if (n_fail_shown <= 30)
                $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic void model_reset();
        m_cmd = 16'h0000; m_rdy = 1'b0; m_lo = 1'b0; m_hold = 8'h00; m_hi_at = 0;
        m_tx_on = 1'b0; m_sent = 1'b0; m_tx_s = 0; m_tx_frame = 10'h3FF;
        evq.delete();
    endfunction

    function automatic void apply_ev(rx_ev_t ev);
        if (!ev.ok) begin
            m_frm = 1'b1;
            m_lo  = 1'b0;
        end else begin
            if (m_lo && (ev.start - m_hi_at) > TMO) m_lo = 1'b0;
            if (!m_lo) begin
                m_hold = ev.b; m_rdy = 1'b0; m_lo = 1'b1; m_hi_at = ev.at;
            end else begin
                m_cmd = {m_hold, ev.b}; m_rdy = 1'b1; m_lo = 1'b0;
            end
        end
    endfunction

    // Compare process: inputs captured at the edge, outputs checked 1 time unit later.
    always @(posedge clk) begin
        logic       rst_smp, clr_smp, send_smp;
        logic [7:0] resp_smp;
        logic       exp_tx;
        int         idx;
        rst_smp = rst_n; clr_smp = clr_cmd_rdy; send_smp = send_resp; resp_smp = resp;
        #1;
        cyc++;
        m_frm = 1'b0;
        if (!rst_smp) begin
            model_reset();
        end else begin
            if (clr_smp) m_rdy = 1'b0;
            while (evq.size() > 0 && evq[0].at == cyc) apply_ev(evq.pop_front());
            if (send_smp && !m_tx_on) begin
                m_tx_on = 1'b1; m_tx_s = cyc; m_tx_frame = {1'b1, resp_smp, 1'b0}; m_sent = 1'b0;
            end
            if (m_tx_on && cyc >= m_tx_s + 10 * B) begin
                m_tx_on = 1'b0; m_sent = 1'b1;
            end
        end
        exp_tx = 1'b1;
        if (m_tx_on) begin
            idx = (cyc - m_tx_s) / B;
            exp_tx = m_tx_frame[idx];
        end
        if (frm_err === 1'b1) frm_seen++;
        chk("cmd", {16'h0, cmd}, {16'h0, m_cmd});
        chk("cmd_rdy", {31'h0, cmd_rdy}, {31'h0, m_rdy});
        chk("frm_err", {31'h0, frm_err}, {31'h0, m_frm});
        chk("TX", {31'h0, TX}, {31'h0, exp_tx});
        chk("tx_busy", {31'h0, tx_busy}, {31'h0, m_tx_on});
        chk("resp_sent", {31'h0, resp_sent}, {31'h0, m_sent});
    end

    task automatic uart_send(input logic [7:0] b, input bit stop_ok);
        int         c;
        logic [9:0] f;
        rx_ev_t     ev;
        @(negedge clk);
        c = cyc;
        f = {stop_ok, b, 1'b0};
        ev.at = stop_ok ? c + 4 + H + 9 * B : c + 3 + H + 9 * B;
        ev.start = c; ev.b = b; ev.ok = stop_ok;
        evq.push_back(ev);
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (B) @(negedge clk);
        end
        RX = 1'b1;
    endtask

    task automatic uart_cmd(input logic [15:0] w);
        uart_send(w[15:8], 1'b1);
        uart_send(w[7:0], 1'b1);
    endtask

    task automatic pulse_send(input logic [7:0] r);
        @(negedge clk); resp = r; send_resp = 1'b1;
        @(negedge clk); send_resp = 1'b0; resp = 8'h00;
    endtask

    // Plays the RemoteComm side: finds the start bit and samples each bit mid-cell.
    task automatic remote_rx(output logic [9:0] bits);
        int guard;
        guard = 0;
        bits = 10'h000;
        while (TX !== 1'b0 && guard < 4 * B) begin
            @(negedge clk); guard++;
        end
        chk("rc_start_seen", {31'h0, TX}, 32'h0);
        repeat (H) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            bits[i] = TX;
            if (i < 9) repeat (B) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [9:0] got;
        logic [9:0] ack_seq;
        int         f0;
        model_reset();
        m_frm = 1'b0;
        ack_seq = 10'b11_0100_1010;
        repeat (3) @(negedge clk);
        chk("rst_cmd", {16'h0, cmd}, 32'h0);
        chk("rst_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("rst_TX", {31'h0, TX}, 32'h1);
        chk("rst_busy", {31'h0, tx_busy}, 32'h0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        uart_cmd(16'h4002);
        chk("lit_4002", {16'h0, cmd}, 32'h4002);
        chk("lit_4002_rdy", {31'h0, cmd_rdy}, 32'h1);
        @(negedge clk); clr_cmd_rdy = 1'b1;
        @(negedge clk); clr_cmd_rdy = 1'b0;
        chk("clr_rdy", {31'h0, cmd_rdy}, 32'h0);

        uart_cmd(16'h2000);
        uart_send(8'h23, 1'b1);
        chk("hi_keeps_cmd", {16'h0, cmd}, 32'h2000);
        chk("hi_clears_rdy", {31'h0, cmd_rdy}, 32'h0);
        uart_send(8'hFF, 1'b1);
        chk("lit_23ff", {16'h0, cmd}, 32'h23FF);

        uart_send(8'h40, 1'b1);
        repeat (3 * TMO) @(negedge clk);
        uart_cmd(16'h2C00);
        chk("tmo_resync", {16'h0, cmd}, 32'h2C00);
        chk("model_tmo", {16'h0, m_cmd}, 32'h2C00);

        f0 = frm_seen;
        uart_send(8'h55, 1'b0);
        repeat (B) @(negedge clk);
        chk("frm_once", frm_seen - f0, 32'd1);
        uart_cmd(16'h1234);
        chk("after_frm", {16'h0, cmd}, 32'h1234);

        // Set and clear land on the same edge: the set must win.
        uart_send(8'h77, 1'b1);
        fork
            uart_send(8'h88, 1'b1);
            begin
                @(negedge clk);
                repeat (3 + H + 9 * B) @(negedge clk);
                clr_cmd_rdy = 1'b1;
                @(negedge clk); clr_cmd_rdy = 1'b0;
            end
        join
        chk("set_wins", {31'h0, cmd_rdy}, 32'h1);
        chk("lit_7788", {16'h0, cmd}, 32'h7788);

        fork
            pulse_send(8'hA5);
            remote_rx(got);
            begin
                repeat (3 * B) @(negedge clk);
                pulse_send(8'h00);
            end
        join
        chk("ack_bits", {22'h0, got}, {22'h0, ack_seq});
        chk("ack_byte", {24'h0, got[8:1]}, 32'hA5);
        repeat (2 * B) @(negedge clk);
        chk("resp_sent_end", {31'h0, resp_sent}, 32'h1);
        chk("busy_end", {31'h0, tx_busy}, 32'h0);

        uart_cmd(16'h5A5A);
        uart_send(8'h12, 1'b1);
        pulse_send(8'h3C);
        RX = 1'b0; repeat (B) @(negedge clk);
        RX = 1'b1; repeat (B) @(negedge clk);
        RX = 1'b0; repeat (B) @(negedge clk);
        RX = 1'b1; rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_TX", {31'h0, TX}, 32'h1);
        chk("rst_mid_busy", {31'h0, tx_busy}, 32'h0);
        chk("rst_mid_rdy", {31'h0, cmd_rdy}, 32'h0);
        chk("rst_mid_cmd", {16'h0, cmd}, 32'h0);
        rst_n = 1'b1;
        repeat (2 * B) @(negedge clk);
        uart_cmd(16'h0000);
        chk("post_rst_rdy", {31'h0, cmd_rdy}, 32'h1);
        chk("post_rst_cmd", {16'h0, cmd}, 32'h0);
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cmd_uart_link.md
# cmd_uart_link

DUT-side end of the Bluetooth command link: receives 8N1 UART bytes on `RX`, assembles the two-byte command (high byte first) sent by `RemoteComm` into a 16-bit `cmd` with a `cmd_rdy` handshake, and serializes 8-bit responses (e.g. 0xA5 positive acknowledge) back on `TX`. It sits inside `MazeRunner` between the `RX`/`TX` pins and the command processor.

## Interface
- `BAUD_DIV`, 2604, clocks per bit (50 MHz / 19200 baud); must be ≥ 8.
- `BYTE_TMO`, 2^20, clocks allowed between high-byte stop and low-byte start before resync.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset; one clock, reset is synchronous and active-low.
- `RX`  in  1  asynchronous serial input, idles high.
- `TX`  out  1  serial output, idles high.
- `cmd`  out  16  last complete command; {high byte, low byte}.
- `cmd_rdy`  out  1  level; a new `cmd` is valid.
- `clr_cmd_rdy`  in  1  pulse from consumer; clears `cmd_rdy`.
- `resp`  in  8  response byte, sampled on `send_resp`.
- `send_resp`  in  1  pulse; start transmitting `resp`.
- `tx_busy`  out  1  transmitter active.
- `resp_sent`  out  1  level; last response fully shifted out.
- `frm_err`  out  1  one-cycle pulse on a stop-bit error.

## Operation
- RX path: `RX` double-flopped (both flops reset to 1). States IDLE, START, DATA, STOP.
  - IDLE: synced falling edge → START, bit counter loaded with BAUD_DIV/2.
  - START: at mid-bit, if line high (glitch) → IDLE, else → DATA with counter BAUD_DIV.
  - DATA: 8 samples at mid-bit, LSB first into a shift register.
  - STOP: mid-bit sample; 1 → byte valid (1-cycle `byte_rdy`), 0 → `frm_err` pulse, byte discarded. Either → IDLE.
- Assembler FSM: WAIT_HI, WAIT_LO.
  - WAIT_HI + `byte_rdy`: byte → holding register, clear `cmd_rdy`, → WAIT_LO, clear timeout counter.
  - WAIT_LO + `byte_rdy`: `cmd` ← {holding, byte} in one cycle, set `cmd_rdy`, → WAIT_HI.
  - WAIT_LO, timeout counter reaches BYTE_TMO with RX FSM in IDLE: → WAIT_HI, holding byte dropped, `cmd` unchanged.
  - `frm_err` in either state → WAIT_HI (resync).
- `cmd` changes only at the WAIT_LO completion cycle; never shows a half-updated value.
- `cmd_rdy`: set on completion; cleared by `clr_cmd_rdy` or by a new high byte. Set and `clr_cmd_rdy` in the same cycle → set wins.
- TX path: states IDLE, XMIT. `send_resp` in IDLE latches {1, resp, 0} into a 10-bit shift register, clears `resp_sent`, asserts `tx_busy`. Each BAUD_DIV clocks shift one bit LSB first. After 10 bits → IDLE, `tx_busy` 0, `resp_sent` 1.
- `send_resp` while `tx_busy` is ignored (no queuing, `resp` not re-sampled).
- RX and TX are fully independent (full duplex).

## Timing
- Reset values: `TX`=1, `cmd`=0x0000, `cmd_rdy`=0, `tx_busy`=0, `resp_sent`=0, `frm_err`=0; both FSMs idle.
- Reset asserted mid-frame: everything is back to reset values on the next edge; the partial byte and holding byte are lost.
- RX latency: `cmd_rdy` rises 1 clock after the low byte's stop-bit mid-sample (≈9.5 bit times + 3 clocks after its start edge, including the 2-flop synchronizer).
- TX latency: `TX` falls on the clock after `send_resp` is sampled. Each bit lasts exactly BAUD_DIV clocks. `resp_sent` rises together with the `tx_busy` fall, 10×BAUD_DIV+1 clocks after `send_resp`.
- Counters: bit counter is ⌈log2 BAUD_DIV⌉+1 bits and counts down to 0. The timeout counter saturates and does not wrap.

## Structure
- Shared package `maze_pkg`: `rx_state_t`, `asm_state_t`, `tx_state_t` enums, `BAUD_DIV_50M_19K2` constant, `POS_ACK` = 8'hA5.
- One natural sub-module: `uart_rx_core` (synchronizer + RX FSM, outputs `rx_byte`, `byte_rdy`, `frm_err`, `rx_idle`). The assembler and TX stay in `cmd_uart_link`.

## Test plan
- BAUD_DIV=16, `RemoteComm` drives 0x4002 → `cmd`=0x4002 and `cmd_rdy`=1 within 1 clock of the 2nd stop mid-sample; `clr_cmd_rdy` → 0 next cycle.
- 0x2000 held (`cmd_rdy` not cleared), then 0x23FF sent → `cmd_rdy` falls at the 0x23 byte, `cmd` stays 0x2000 until the 0xFF byte completes, then 0x23FF.
- High byte 0x40 only, idle > BYTE_TMO, then 0x2C, 0x00 → `cmd`=0x2C00, never 0x402C.
- Stop bit forced 0 on the high byte → `frm_err` pulses once, FSM in WAIT_HI; the next full pair decodes correctly.
- `send_resp` with `resp`=0xA5 → `TX` shows 0,1,0,1,0,0,1,0,1,1 at 16-clock spacing and `RemoteComm` reports 0xA5. A 2nd `send_resp` mid-frame with 0x00 is ignored. `resp_sent`=1 at the end.
- `rst_n` low mid-TX and mid-RX → `TX`=1, `tx_busy`=0, `cmd_rdy`=0 on the next edge; a subsequent 0x0000 command decodes.
